// File: rtl/cnn_acc_requant_pkg.sv
// Shared types and width constants for the conv accumulate/requantize stage.
package cnn_acc_requant_pkg;

  localparam int unsigned PROD_WIDTH = 24;
  localparam int unsigned ACC_WIDTH  = 32;
  localparam int unsigned OUT_WIDTH  = 10;

  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    ROUND = 2'd1,
    OUT   = 2'd2
  } state_t;

  // Requantized activation plus clamp flag.
  typedef struct packed {
    logic                        sat;
    logic signed [OUT_WIDTH-1:0] data;
  } rq_result_t;

endpackage

// File: rtl/cnn_requant_round_sat.sv
// Combinational round-half-up, arithmetic shift, optional ReLU and clamp to
// the output activation range.
module cnn_requant_round_sat
  import cnn_acc_requant_pkg::*;
#(
  parameter int unsigned FRAC_SHIFT = 8,
  parameter int unsigned RELU       = 1
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output rq_result_t                  res_c
);

  // One guard bit so adding the rounding half never wraps.
  localparam int unsigned EXT_WIDTH = ACC_WIDTH + 1;
  localparam logic signed [EXT_WIDTH-1:0] HALF   = EXT_WIDTH'(1) << (FRAC_SHIFT - 1);
  localparam logic signed [EXT_WIDTH-1:0] OUT_HI = EXT_WIDTH'(OUT_MAX);
  localparam logic signed [EXT_WIDTH-1:0] OUT_LO = EXT_WIDTH'(OUT_MIN);

  logic signed [EXT_WIDTH-1:0] ext_c;
  logic signed [EXT_WIDTH-1:0] shr_c;

  // Round, shift, then ReLU (not flagged) or clamp (flagged).
  always_comb begin
    ext_c = {acc[ACC_WIDTH-1], acc} + HALF;
    shr_c = ext_c >>> FRAC_SHIFT;
    res_c = '0;
    if ((RELU != 0) && shr_c[EXT_WIDTH-1]) begin
      res_c.data = '0;
      res_c.sat  = 1'b0;
    end else if (shr_c > OUT_HI) begin
      res_c.data = OUT_MAX;
      res_c.sat  = 1'b1;
    end else if (shr_c < OUT_LO) begin
      res_c.data = OUT_MIN;
      res_c.sat  = 1'b1;
    end else begin
      res_c.data = shr_c[OUT_WIDTH-1:0];
      res_c.sat  = 1'b0;
    end
  end

endmodule

// File: rtl/cnn_acc_requant.sv
// Accumulates a group of signed products plus bias, then requantizes the sum
// to the next layer's activation format with a valid/ready output.
module cnn_acc_requant
  import cnn_acc_requant_pkg::*;
#(
  parameter int unsigned FRAC_SHIFT = 8,
  parameter int unsigned RELU       = 1
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [PROD_WIDTH-1:0] in_data,
  input  logic                         in_last,
  input  logic signed [ACC_WIDTH-1:0]  bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_sat
);

  localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                      state;
  logic                        first;
  logic                        acc_sat;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_base_c;
  logic signed [ACC_WIDTH-1:0] acc_next_c;
  logic signed [SUM_WIDTH-1:0] sum_c;
  logic                        ovf_c;
  logic                        beat_c;
  rq_result_t                  rq_c;

  assign beat_c = in_valid && in_ready;

  // Saturating add of the product onto bias (first beat) or running sum.
  always_comb begin
    acc_base_c = first ? bias : acc;
    sum_c      = {acc_base_c[ACC_WIDTH-1], acc_base_c}
               + {{(SUM_WIDTH-PROD_WIDTH){in_data[PROD_WIDTH-1]}}, in_data};
    ovf_c      = sum_c[SUM_WIDTH-1] != sum_c[SUM_WIDTH-2];
    acc_next_c = sum_c[ACC_WIDTH-1:0];
    if (ovf_c) begin
      acc_next_c = sum_c[SUM_WIDTH-1] ? ACC_MIN : ACC_MAX;
    end
  end

  cnn_requant_round_sat #(
    .FRAC_SHIFT (FRAC_SHIFT),
    .RELU       (RELU)
  ) u_round_sat (
    .acc   (acc),
    .res_c (rq_c)
  );

  // Group FSM; in_ready is registered alongside state so it always equals (state == ACC).
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= ACC;
      first     <= 1'b1;
      acc       <= '0;
      acc_sat   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (beat_c) begin
            acc     <= acc_next_c;
            acc_sat <= (!first && acc_sat) || ovf_c;
            first   <= 1'b0;
            if (in_last) begin
              state    <= ROUND;
              in_ready <= 1'b0;
            end
          end
        end
        ROUND: begin
          out_data  <= rq_c.data;
          out_sat   <= rq_c.sat || acc_sat;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            first     <= 1'b1;
            in_ready  <= 1'b1;
            state     <= ACC;
          end
        end
        default: begin
          state     <= ACC;
          first     <= 1'b1;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_acc_requant.sv
// Scoreboard bench: a linear (RELU=0) and a ReLU (RELU=1) instance share the
// same input stream; each has its own expected-result queue and monitor.
module tb_cnn_acc_requant;
  import cnn_acc_requant_pkg::*;

  logic                         ap_clk = 1'b0;
  logic                         ap_rst;
  logic                         in_valid;
  logic signed [PROD_WIDTH-1:0] in_data;
  logic                         in_last;
  logic signed [ACC_WIDTH-1:0]  bias;
  logic                         out_ready;

  logic                         lin_in_ready, lin_out_valid, lin_out_sat;
  logic signed [OUT_WIDTH-1:0]  lin_out_data;
  logic                         relu_in_ready, relu_out_valid, relu_out_sat;
  logic signed [OUT_WIDTH-1:0]  relu_out_data;

  rq_result_t q_lin[$];
  rq_result_t q_relu[$];
  int         pq[$];
  int         n_vec = 0;
  int         n_err = 0;

  always #5 ap_clk = ~ap_clk;

  cnn_acc_requant #(.FRAC_SHIFT(8), .RELU(0)) u_lin (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (in_valid),
    .in_ready  (lin_in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .bias      (bias),
    .out_valid (lin_out_valid),
    .out_ready (out_ready),
    .out_data  (lin_out_data),
    .out_sat   (lin_out_sat)
  );

  cnn_acc_requant #(.FRAC_SHIFT(8), .RELU(1)) u_relu (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (in_valid),
    .in_ready  (relu_in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .bias      (bias),
    .out_valid (relu_out_valid),
    .out_ready (out_ready),
    .out_data  (relu_out_data),
    .out_sat   (relu_out_sat)
  );

  // Linear-instance monitor: compare on each completed output handshake.
  always @(negedge ap_clk) begin : mon_lin
    rq_result_t e;
    if (!ap_rst && lin_out_valid && out_ready) begin
      n_vec++;
      if (q_lin.size() == 0) begin
        n_err++;
        $display("FAIL lin_unexpected: got data=%0d sat=%0b, want no result", lin_out_data, lin_out_sat);
      end else begin
        e = q_lin.pop_front();
        if (lin_out_data !== e.data || lin_out_sat !== e.sat) begin
          n_err++;
          $display("FAIL lin_result: got data=%0d sat=%0b, want data=%0d sat=%0b",
                   lin_out_data, lin_out_sat, e.data, e.sat);
        end
      end
    end
  end

  // ReLU-instance monitor.
  always @(negedge ap_clk) begin : mon_relu
    rq_result_t e;
    if (!ap_rst && relu_out_valid && out_ready) begin
      n_vec++;
      if (q_relu.size() == 0) begin
        n_err++;
        $display("FAIL relu_unexpected: got data=%0d sat=%0b, want no result", relu_out_data, relu_out_sat);
      end else begin
        e = q_relu.pop_front();
        if (relu_out_data !== e.data || relu_out_sat !== e.sat) begin
          n_err++;
          $display("FAIL relu_result: got data=%0d sat=%0b, want data=%0d sat=%0b",
                   relu_out_data, relu_out_sat, e.data, e.sat);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Present one beat and hold it until both instances accept it.
  task automatic send(input int d, input bit last, input int b);
    int waited;
    bit rdy;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = PROD_WIDTH'(d);
    in_last  = last;
    bias     = ACC_WIDTH'(b);
    forever begin
      @(negedge ap_clk);
      rdy = lin_in_ready && relu_in_ready;
      @(posedge ap_clk);
      #1;
      if (rdy) break;
      waited++;
      if (waited > 100) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: in_ready low for %0d cycles, want 1", waited);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input int el, input bit sl, input int er, input bit sr);
    rq_result_t x;
    x.sat = sl;
    x.data = OUT_WIDTH'(el);
    q_lin.push_back(x);
    x.sat = sr;
    x.data = OUT_WIDTH'(er);
    q_relu.push_back(x);
  endtask

  // Send the beats in pq as one group with the given bias.
  task automatic run_group(input int b, input int el, input bit sl, input int er, input bit sr);
    expect_result(el, sl, er, sr);
    for (int i = 0; i < pq.size(); i++) begin
      send(pq[i], (i == pq.size() - 1), b);
    end
  endtask

  task automatic single(input int b, input int p, input int el, input bit sl, input int er, input bit sr);
    pq = '{p};
    run_group(b, el, sl, er, sr);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_lin.size() != 0 || q_relu.size() != 0) && n < 50) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    if (q_lin.size() != 0 || q_relu.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d/%0d results outstanding, want 0", q_lin.size(), q_relu.size());
    end
  endtask

  initial begin
    ap_rst    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    bias      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;

    chk("rst_lin_in_ready",   int'(lin_in_ready),   1);
    chk("rst_lin_out_valid",  int'(lin_out_valid),  0);
    chk("rst_lin_out_data",   int'(lin_out_data),   0);
    chk("rst_lin_out_sat",    int'(lin_out_sat),    0);
    chk("rst_relu_in_ready",  int'(relu_in_ready),  1);
    chk("rst_relu_out_valid", int'(relu_out_valid), 0);

    // Basic three-beat group and output latency.
    pq = '{256, 512, -128};
    run_group(0, 3, 1'b0, 3, 1'b0);
    chk("lat_round_valid", int'(lin_out_valid), 0);
    @(posedge ap_clk);
    #1;
    chk("lat_out_valid", int'(lin_out_valid), 1);
    drain();

    // Rounding half toward +inf.
    single(0, 384,  2, 1'b0, 2, 1'b0);
    single(0, -384, -1, 1'b0, 0, 1'b0);
    single(0, 128,  1, 1'b0, 1, 1'b0);
    single(0, -129, -1, 1'b0, 0, 1'b0);
    drain();

    // Output clamps and ReLU.
    pq.delete();
    repeat (10) pq.push_back(8388607);
    run_group(0, 511, 1'b1, 511, 1'b1);
    single(0, -5000,    -20, 1'b0, 0, 1'b0);
    single(0, -8388608, -512, 1'b1, 0, 1'b0);
    single(0, 130816,   511, 1'b0, 511, 1'b0);
    single(0, 130944,   511, 1'b1, 511, 1'b1);
    drain();

    // Accumulator saturation sticks into out_sat.
    single(32'sh7fffffff, 8388607, 511, 1'b1, 511, 1'b1);
    single(32'sh80000000, -1,     -512, 1'b1, 0,   1'b1);
    drain();

    // Backpressure: result held, next beat waits upstream.
    out_ready = 1'b0;
    pq = '{1000, 1000};
    run_group(100, 8, 1'b0, 8, 1'b0);
    @(posedge ap_clk);
    #1;
    expect_result(10, 1'b0, 10, 1'b0);
    in_valid = 1'b1;
    in_data  = PROD_WIDTH'(2560);
    in_last  = 1'b1;
    bias     = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      chk("bp_out_valid", int'(lin_out_valid), 1);
      chk("bp_out_data",  int'(lin_out_data),  8);
      chk("bp_in_ready",  int'(lin_in_ready),  0);
    end
    @(posedge ap_clk);
    #1;
    out_ready = 1'b1;
    send(2560, 1'b1, 0);
    drain();

    // Reset mid-group discards the partial sum.
    send(25600, 1'b0, 0);
    send(25600, 1'b0, 0);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    chk("midrst_in_ready",  int'(lin_in_ready),  1);
    chk("midrst_out_valid", int'(lin_out_valid), 0);
    single(0, 256, 1, 1'b0, 1, 1'b0);
    drain();

    // Single-beat group picks up bias.
    single(1000, 24, 4, 1'b0, 4, 1'b0);
    drain();

    repeat (3) @(posedge ap_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
